// File: rtl/tpu_sequencer.sv
// Job sequencer for the systolic-array datapath. One job loads a weight slot
// from the weight store, streams num_rows input vectors out of the Unified
// Buffer, then writes the matching results LATENCY cycles after each read.
//
// Handshake: start is a level request taken only in IDLE (a start seen while
// busy is dropped, never queued); abort cancels the job in flight; done is a
// single-cycle pulse in the DONE state. Every strobe is combinational from
// registered state, so reset clears all outputs without waiting for a clock.
module tpu_sequencer #(
    parameter int ADDRESSSIZE      = 10,
    parameter int ADDRESSSIZE_fifo = 2,
    parameter int LATENCY          = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        start,
    input  logic                        abort,
    input  logic [ADDRESSSIZE-1:0]      num_rows,
    input  logic [ADDRESSSIZE-1:0]      ub_base,
    input  logic [ADDRESSSIZE-1:0]      res_base,
    input  logic [ADDRESSSIZE_fifo-1:0] weight_slot,
    output logic [ADDRESSSIZE_fifo-1:0] fifo_address,
    output logic                        we_rl,
    output logic                        ub_rd_en,
    output logic [ADDRESSSIZE-1:0]      ub_rd_addr,
    output logic                        res_wr_en,
    output logic [ADDRESSSIZE-1:0]      res_wr_addr,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WLOAD1 = 3'd1,
        WLOAD2 = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_e;

    localparam logic [ADDRESSSIZE-1:0] ONE = ADDRESSSIZE'(1);

    state_e                      state_q, state_d;
    logic [ADDRESSSIZE-1:0]      num_rows_q, num_rows_d;
    logic [ADDRESSSIZE-1:0]      ub_base_q, ub_base_d;
    logic [ADDRESSSIZE-1:0]      res_base_q, res_base_d;
    logic [ADDRESSSIZE_fifo-1:0] slot_q, slot_d;
    logic [ADDRESSSIZE-1:0]      rd_idx_q, rd_idx_d;
    logic [ADDRESSSIZE-1:0]      wr_idx_q, wr_idx_d;
    // Bit k set means a UB read issued k+1 cycles ago is still in flight.
    logic [LATENCY-1:0]          vld_q, vld_d;

    // State, latched job parameters, row counters and the valid delay line.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            num_rows_q <= '0;
            ub_base_q  <= '0;
            res_base_q <= '0;
            slot_q     <= '0;
            rd_idx_q   <= '0;
            wr_idx_q   <= '0;
            vld_q      <= '0;
        end else begin
            state_q    <= state_d;
            num_rows_q <= num_rows_d;
            ub_base_q  <= ub_base_d;
            res_base_q <= res_base_d;
            slot_q     <= slot_d;
            rd_idx_q   <= rd_idx_d;
            wr_idx_q   <= wr_idx_d;
            vld_q      <= vld_d;
        end
    end

    // Output decode from current state, then next-state and counter updates.
    always_comb begin
        fifo_address = '0;
        we_rl        = 1'b0;
        ub_rd_en     = 1'b0;
        ub_rd_addr   = '0;
        res_wr_en    = 1'b0;
        res_wr_addr  = '0;
        busy         = 1'b0;
        done         = 1'b0;
        state_d      = state_q;
        num_rows_d   = num_rows_q;
        ub_base_d    = ub_base_q;
        res_base_d   = res_base_q;
        slot_d       = slot_q;
        rd_idx_d     = rd_idx_q;
        wr_idx_d     = wr_idx_q;
        vld_d        = vld_q;

        busy  = (state_q != IDLE);
        done  = (state_q == DONE);
        we_rl = (state_q == WLOAD2);
        if (busy) begin
            fifo_address = slot_q;
        end
        // Addresses wrap naturally at the ADDRESSSIZE boundary.
        if (state_q == STREAM) begin
            ub_rd_en   = 1'b1;
            ub_rd_addr = ub_base_q + rd_idx_q;
        end
        res_wr_en = vld_q[LATENCY-1];
        if (res_wr_en) begin
            res_wr_addr = res_base_q + wr_idx_q;
            wr_idx_d    = wr_idx_q + ONE;
        end
        vld_d = {vld_q[LATENCY-2:0], ub_rd_en};

        case (state_q)
            IDLE: begin
                if (start) begin
                    num_rows_d = num_rows;
                    ub_base_d  = ub_base;
                    res_base_d = res_base;
                    slot_d     = weight_slot;
                    rd_idx_d   = '0;
                    wr_idx_d   = '0;
                    state_d    = (num_rows == '0) ? DONE : WLOAD1;
                end
            end
            WLOAD1: state_d = WLOAD2;
            WLOAD2: state_d = STREAM;
            STREAM: begin
                rd_idx_d = rd_idx_q + ONE;
                if (rd_idx_q == num_rows_q - ONE) begin
                    state_d = DRAIN;
                end
            end
            // Leave once at most the oldest entry remains: that write is
            // happening in this very cycle.
            DRAIN: begin
                if (vld_q[LATENCY-2:0] == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d = IDLE;
            vld_d   = '0;
        end
    end

endmodule

// File: tb/tb_tpu_sequencer.sv
// Bench for tpu_sequencer: directed scenarios with literal cycle pins, then
// randomized jobs, aborts and resets checked every cycle against a job-level
// model (when each job starts, and closed-form event cycles derived from it).
module tb_tpu_sequencer;
    localparam int AW = 10;
    localparam int FW = 2;
    localparam int L  = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] num_rows = '0;
    logic [AW-1:0] ub_base = '0;
    logic [AW-1:0] res_base = '0;
    logic [FW-1:0] weight_slot = '0;
    logic [FW-1:0] fifo_address;
    logic          we_rl;
    logic          ub_rd_en;
    logic [AW-1:0] ub_rd_addr;
    logic          res_wr_en;
    logic [AW-1:0] res_wr_addr;
    logic          busy;
    logic          done;

    tpu_sequencer #(
        .ADDRESSSIZE(AW),
        .ADDRESSSIZE_fifo(FW),
        .LATENCY(L)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .start(start),
        .abort(abort),
        .num_rows(num_rows),
        .ub_base(ub_base),
        .res_base(res_base),
        .weight_slot(weight_slot),
        .fifo_address(fifo_address),
        .we_rl(we_rl),
        .ub_rd_en(ub_rd_en),
        .ub_rd_addr(ub_rd_addr),
        .res_wr_en(res_wr_en),
        .res_wr_addr(res_wr_addr),
        .busy(busy),
        .done(done)
    );

    // Clock and reset
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Job model: the single job the block may be running. A job accepted at
    // the edge ending cycle c occupies cycles m_s = c+1 .. m_end.
    bit m_valid = 1'b0;
    int m_s = 0, m_end = 0, m_nat = 0, m_n = 0, m_ub = 0, m_res = 0, m_slot = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=0x%0h want=0x%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic bit model_busy(input int k);
        return m_valid && (k >= m_s) && (k <= m_end);
    endfunction

    // Driver: advance one clock, fold the inputs sampled at that edge into the
    // model, then return 1 time unit later so new inputs land off the edge.
    task automatic step();
        int c;
        @(posedge clk);
        c = cyc;
        if (rstn) begin
            if (model_busy(c)) begin
                if (abort) m_end = c;
            end else if (start) begin
                m_valid = 1'b1;
                m_s     = c + 1;
                m_n     = int'(num_rows);
                m_ub    = int'(ub_base);
                m_res   = int'(res_base);
                m_slot  = int'(weight_slot);
                m_nat   = (m_n == 0) ? m_s : m_s + m_n + L + 2;
                m_end   = m_nat;
            end
        end
        cyc = cyc + 1;
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fifo"}, int'(fifo_address), 0);
        chk({tag, "_we_rl"}, int'(we_rl), 0);
        chk({tag, "_rd_en"}, int'(ub_rd_en), 0);
        chk({tag, "_rd_addr"}, int'(ub_rd_addr), 0);
        chk({tag, "_wr_en"}, int'(res_wr_en), 0);
        chk({tag, "_wr_addr"}, int'(res_wr_addr), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    // Scoreboard: compare every output against the model each mid-cycle.
    always @(negedge clk) begin : cmp
        int  k;
        bit  eb, ed, ew, er, ewr;
        k = cyc;
        if (!rstn) begin
            chk_all_zero("rst");
        end else begin
            eb  = model_busy(k);
            ed  = eb && (k == m_nat);
            ew  = eb && (m_n > 0) && (k == m_s + 1);
            er  = eb && (m_n > 0) && (k >= m_s + 2) && (k <= m_s + m_n + 1);
            ewr = eb && (m_n > 0) && (k >= m_s + 2 + L) && (k <= m_s + m_n + 1 + L);
            chk("busy", int'(busy), int'(eb));
            chk("done", int'(done), int'(ed));
            chk("we_rl", int'(we_rl), int'(ew));
            chk("ub_rd_en", int'(ub_rd_en), int'(er));
            chk("res_wr_en", int'(res_wr_en), int'(ewr));
            if (eb && m_n > 0) chk("fifo_address", int'(fifo_address), m_slot);
            if (er) chk("ub_rd_addr", int'(ub_rd_addr), (m_ub + k - m_s - 2) % 1024);
            if (ewr) chk("res_wr_addr", int'(res_wr_addr), (m_res + k - m_s - 2 - L) % 1024);
        end
    end

    // Hand-computed cycle expectations, rel = 1 is the first busy cycle.
    task automatic pin(input int scen, input int rel);
        case (scen)
            1: case (rel)
                1:  chk("s1_fifo", int'(fifo_address), 2);
                2:  chk("s1_we_rl", int'(we_rl), 1);
                3:  chk("s1_rd0", int'(ub_rd_addr), 'h010);
                4:  chk("s1_rd1", int'(ub_rd_addr), 'h011);
                5:  chk("s1_rd2", int'(ub_rd_addr), 'h012);
                19: chk("s1_wr0", int'(res_wr_addr), 'h020);
                20: chk("s1_wr1", int'(res_wr_addr), 'h021);
                21: chk("s1_wr2", int'(res_wr_addr), 'h022);
                22: chk("s1_done", int'(done), 1);
                23: chk("s1_idle", int'(busy), 0);
                default: ;
            endcase
            2: case (rel)
                3:  chk("s2_rd0", int'(ub_rd_addr), 'h3FF);
                4:  chk("s2_rd1", int'(ub_rd_addr), 'h000);
                19: chk("s2_wr0", int'(res_wr_addr), 'h3FF);
                20: chk("s2_wr1", int'(res_wr_addr), 'h000);
                21: chk("s2_done", int'(done), 1);
                default: ;
            endcase
            3: case (rel)
                1: begin
                    chk("s3_busy", int'(busy), 1);
                    chk("s3_done", int'(done), 1);
                end
                2: chk("s3_idle", int'(busy), 0);
                default: ;
            endcase
            4: case (rel)
                5:  chk("s4_idle", int'(busy), 0);
                19: chk("s4_no_wr0", int'(res_wr_en), 0);
                20: chk("s4_no_wr1", int'(res_wr_en), 0);
                default: ;
            endcase
            5: case (rel)
                20: chk("s5_done1", int'(done), 1);
                21: chk("s5_gap", int'(busy), 0);
                22: chk("s5_busy2", int'(busy), 1);
                23: chk("s5_we_rl2", int'(we_rl), 1);
                default: ;
            endcase
            default: ;
        endcase
    endtask

    // Directed job: pins, plus scenario-specific abort / reset / held start.
    task automatic run_job(input int scen, input int n, input int ub, input int res,
                           input int slot, input int len);
        int s0;
        num_rows    = AW'(n);
        ub_base     = AW'(ub);
        res_base    = AW'(res);
        weight_slot = FW'(slot);
        start       = 1'b1;
        step();
        s0 = cyc;
        if (scen != 5) start = 1'b0;
        // Scrambled inputs must not disturb the latched job.
        num_rows = AW'($urandom_range(0, 1023));
        ub_base  = AW'($urandom_range(0, 1023));
        res_base = AW'($urandom_range(0, 1023));
        for (int rel = 1; rel <= len; rel++) begin
            @(negedge clk);
            pin(scen, rel);
            if (scen == 4) abort = (rel == 4);
            if (scen == 6 && rel == 10) begin
                #2 rstn = 1'b0;
                m_valid = 1'b0;
                #1 chk_all_zero("s6_async");
            end
            if (scen == 6 && rel == 12) #2 rstn = 1'b1;
            if (scen == 5 && rel == 21) begin
                num_rows = AW'(1);
                ub_base  = AW'(5);
                res_base = AW'(6);
            end
            step();
            if (cyc != s0 + rel) chk("cycle_track", cyc, s0 + rel);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        // Reset
        #1 chk_all_zero("por");
        repeat (3) step();
        rstn = 1'b1;
        repeat (2) step();

        run_job(1, 3, 'h010, 'h020, 2, 24);
        run_job(2, 2, 'h3FF, 'h3FF, 1, 23);
        run_job(3, 0, 'h100, 'h200, 3, 3);
        run_job(4, 5, 'h040, 'h080, 0, 25);
        run_job(5, 1, 'h001, 'h002, 3, 44);
        run_job(6, 3, 'h030, 'h060, 1, 14);
        run_job(0, 4, 'h111, 'h222, 2, 4 + L + 4);

        // Random jobs, ignored starts, aborts and reset pulses.
        for (int i = 0; i < 4000; i++) begin
            if (model_busy(cyc)) begin
                start       = ($urandom_range(0, 3) == 0);
                abort       = ($urandom_range(0, 149) == 0);
                num_rows    = AW'($urandom_range(0, 1023));
                ub_base     = AW'($urandom_range(0, 1023));
                res_base    = AW'($urandom_range(0, 1023));
                weight_slot = FW'($urandom_range(0, 3));
            end else begin
                abort = 1'b0;
                start = ($urandom_range(0, 2) == 0);
                case ($urandom_range(0, 9))
                    0:       num_rows = '0;
                    1, 2:    num_rows = AW'($urandom_range(9, 40));
                    default: num_rows = AW'($urandom_range(1, 8));
                endcase
                if ($urandom_range(0, 2) == 0) begin
                    ub_base  = AW'($urandom_range(1008, 1023));
                    res_base = AW'($urandom_range(1008, 1023));
                end else begin
                    ub_base  = AW'($urandom_range(0, 1023));
                    res_base = AW'($urandom_range(0, 1023));
                end
                weight_slot = FW'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 799) == 0) begin
                #2 rstn = 1'b0;
                m_valid = 1'b0;
                start   = 1'b0;
                abort   = 1'b0;
                #1 chk_all_zero("rnd_async");
                step();
                step();
                rstn = 1'b1;
            end
            step();
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (L + 50) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tpu_sequencer.md
TPU_SEQUENCER -- requirements
Module: tpu_sequencer

Interface
REQ-001 The parameter list SHALL be: ADDRESSSIZE, 10, UB/result SRAM address width; ADDRESSSIZE_fifo, 2, weight-store slot address width; LATENCY, 16, cycles from a UB read-enable cycle to its matching result-write cycle (legal range 2..63).
REQ-002 Port clk, input, 1 bit: single clock; all state SHALL update on the rising edge.
REQ-003 Port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port start, input, 1 bit: job request, sampled in IDLE only.
REQ-005 Port abort, input, 1 bit: synchronous cancel of the current job.
REQ-006 Port num_rows, input, ADDRESSSIZE bits: count of input vectors in the job.
REQ-007 Port ub_base, input, ADDRESSSIZE bits: first Unified Buffer read address.
REQ-008 Port res_base, input, ADDRESSSIZE bits: first result SRAM write address.
REQ-009 Port weight_slot, input, ADDRESSSIZE_fifo bits: weight-store slot to load.
REQ-010 Port fifo_address, output, ADDRESSSIZE_fifo bits: weight-store read address.
REQ-011 Port we_rl, output, 1 bit: weight reload strobe to the systolic array.
REQ-012 Ports ub_rd_en (1 bit) and ub_rd_addr (ADDRESSSIZE bits), outputs: UB read strobe and address.
REQ-013 Ports res_wr_en (1 bit) and res_wr_addr (ADDRESSSIZE bits), outputs: result SRAM write strobe and address.
REQ-014 Ports busy and done, outputs, 1 bit each: job in progress; one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have states IDLE, WLOAD1, WLOAD2, STREAM, DRAIN, DONE; busy SHALL be 1 in every state except IDLE.
REQ-016 In IDLE with start=1 at an edge, the block SHALL latch num_rows, ub_base, res_base and weight_slot, then go to WLOAD1, or to DONE if num_rows=0.
REQ-017 fifo_address SHALL drive the latched slot from WLOAD1 until return to IDLE.
REQ-018 WLOAD1 SHALL last 1 cycle (SRAM read latency); WLOAD2 SHALL last 1 cycle with we_rl=1, then go to STREAM; we_rl SHALL be 0 in all other states.
REQ-019 STREAM SHALL last exactly num_rows cycles, with ub_rd_en=1 and ub_rd_addr = ub_base+i for i=0..num_rows-1, then go to DRAIN.
REQ-020 Address arithmetic SHALL be modulo 2^ADDRESSSIZE: 0x3FF+1 wraps to 0x000 with no error.
REQ-021 Each ub_rd_en cycle SHALL produce res_wr_en=1 exactly LATENCY cycles later (LATENCY-deep valid delay line), with res_wr_addr = res_base+j for the j-th write, also wrapping.
REQ-022 DRAIN SHALL hold until the delay line is empty and the last write cycle has completed, then go to DONE.
REQ-023 DONE SHALL last 1 cycle with done=1, then go to IDLE; done SHALL be 0 otherwise.
REQ-024 start while busy=1 SHALL be ignored and not queued; start in the DONE cycle SHALL be ignored.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE at the next edge and clear the delay line; no further ub_rd_en, res_wr_en or done SHALL occur for that job; abort in IDLE SHALL have no effect; abort takes priority over start.
REQ-026 Latched job inputs SHALL not be affected by input changes during a job.

Reset
REQ-027 While rstn=0, the block SHALL be in IDLE with the delay line cleared, and every output (fifo_address, we_rl, ub_rd_en, ub_rd_addr, res_wr_en, res_wr_addr, busy, done) SHALL be 0 immediately, without waiting for a clock edge.
REQ-028 After reset deassertion mid-job, the block SHALL remain in IDLE until a new start.

Verification
REQ-029 Scenario 1: start at edge 0 with num_rows=3, ub_base=0x010, res_base=0x020, slot=2, LATENCY=16 -> fifo_address=2 from cycle 1; we_rl in cycle 2; ub_rd_addr 0x010..0x012 in cycles 3-5; res_wr_addr 0x020..0x022 in cycles 19-21; done in cycle 22; busy=0 in cycle 23.
REQ-030 Scenario 2: num_rows=2, ub_base=0x3FF, res_base=0x3FF -> reads at 0x3FF then 0x000; writes at 0x3FF then 0x000.
REQ-031 Scenario 3: num_rows=0 -> busy for exactly 1 cycle (DONE), done=1 in that cycle, and no we_rl, ub_rd_en or res_wr_en.
REQ-032 Scenario 4: abort asserted in the 2nd STREAM cycle of a 5-row job -> IDLE next cycle; no res_wr_en and no done thereafter.
REQ-033 Scenario 5: start held high continuously for two jobs -> second job begins only at the edge after IDLE is re-entered; no overlap of writes.
REQ-034 Scenario 6: rstn pulsed low during DRAIN -> all outputs 0 asynchronously; no done; a new start after reset completes normally.
